// File: rtl/ktop_axis_output_fifo.sv
// First-word-fall-through AXI4-Stream FIFO between the constant-adder stage and the write master.
// Outputs a fill level, a programmable-full flag and a count of emitted packets.
module ktop_axis_output_fifo #(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 512,
  parameter int unsigned C_FIFO_DEPTH_LOG2  = 4,
  parameter int unsigned C_PROG_FULL_THRESH = 12
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic [C_FIFO_DEPTH_LOG2:0]      fill_level,
  output logic                            prog_full,
  output logic [31:0]                     pkt_count
);

  localparam int unsigned KW    = C_AXIS_TDATA_WIDTH / 8;
  localparam int unsigned EW    = C_AXIS_TDATA_WIDTH + KW + 1;
  localparam int unsigned DEPTH = 1 << C_FIFO_DEPTH_LOG2;
  localparam logic [C_FIFO_DEPTH_LOG2:0] FILL_MAX = (C_FIFO_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [C_FIFO_DEPTH_LOG2:0] PF_LVL   = (C_FIFO_DEPTH_LOG2 + 1)'(C_PROG_FULL_THRESH);

  logic [EW-1:0]                mem [DEPTH];
  logic [C_FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [C_FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [C_FIFO_DEPTH_LOG2:0]   fill_next;
  logic                         areset_q;
  logic                         push;
  logic                         pop;
  logic [EW-1:0]                head;

  // Ready depends only on flops, so a pop while full never frees a slot in the same cycle.
  assign s_axis_tready = ~areset_q & (fill_level != FILL_MAX);
  assign m_axis_tvalid = (fill_level != '0);
  assign push          = s_axis_tvalid & s_axis_tready;
  assign pop           = m_axis_tvalid & m_axis_tready;

  assign head         = mem[rd_ptr];
  assign m_axis_tdata = head[EW-1 -: C_AXIS_TDATA_WIDTH];
  assign m_axis_tkeep = head[KW:1];
  assign m_axis_tlast = head[0];

  always_comb begin
    fill_next = fill_level;
    if (push && !pop) begin
      fill_next = fill_level + 1'b1;
    end else if (pop && !push) begin
      fill_next = fill_level - 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      areset_q   <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      prog_full  <= 1'b0;
      pkt_count  <= '0;
    end else begin
      areset_q   <= 1'b0;
      fill_level <= fill_next;
      prog_full  <= (fill_next >= PF_LVL);
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (m_axis_tlast) begin
          pkt_count <= pkt_count + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ktop_axis_output_fifo.sv
// Directed and randomized bench for ktop_axis_output_fifo, checked against a queue-based model.
module tb_ktop_axis_output_fifo;

  localparam int W      = 64;
  localparam int K      = W / 8;
  localparam int DL2    = 4;
  localparam int DEPTH  = 1 << DL2;
  localparam int THRESH = 12;

  typedef struct packed {
    logic [W-1:0] data;
    logic [K-1:0] keep;
    logic         last;
  } beat_t;

  logic           clk;
  logic           rst;
  logic           s_tvalid;
  logic           s_tready;
  logic [W-1:0]   s_tdata;
  logic [K-1:0]   s_tkeep;
  logic           s_tlast;
  logic           m_tvalid;
  logic           m_tready;
  logic [W-1:0]   m_tdata;
  logic [K-1:0]   m_tkeep;
  logic           m_tlast;
  logic [DL2:0]   fill;
  logic           pfull;
  logic [31:0]    pkt;

  beat_t          q[$];
  logic [31:0]    pkt_model;
  logic           rst_q_model;
  logic           checking;
  int             n_assert;
  int             n_fail;

  ktop_axis_output_fifo #(
    .C_AXIS_TDATA_WIDTH(W),
    .C_FIFO_DEPTH_LOG2 (DL2),
    .C_PROG_FULL_THRESH(THRESH)
  ) dut (
    .aclk         (clk),
    .areset       (rst),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tdata (s_tdata),
    .s_axis_tkeep (s_tkeep),
    .s_axis_tlast (s_tlast),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tlast (m_tlast),
    .fill_level   (fill),
    .prog_full    (pfull),
    .pkt_count    (pkt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic exp_tready;
    exp_tready = !rst_q_model && (q.size() != DEPTH);
    chk("s_tready", W'(s_tready), W'(exp_tready));
    chk("m_tvalid", W'(m_tvalid), W'(q.size() != 0));
    chk("fill_level", W'(fill), W'(q.size()));
    chk("prog_full", W'(pfull), W'(q.size() >= THRESH));
    chk("pkt_count", W'(pkt), W'(pkt_model));
    if (q.size() != 0) begin
      chk("m_tdata", m_tdata, q[0].data);
      chk("m_tkeep", W'(m_tkeep), W'(q[0].keep));
      chk("m_tlast", W'(m_tlast), W'(q[0].last));
    end
  endtask

  // Called just after a falling edge: drive, check, take the rising edge, update the model.
  task automatic step(input logic sv, input logic [W-1:0] d, input logic [K-1:0] k,
                      input logic l, input logic mr, output logic pushed);
    logic do_push;
    logic do_pop;
    s_tvalid = sv;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    m_tready = mr;
    #1;
    if (checking) check_outputs();
    @(posedge clk);
    pushed = 1'b0;
    if (rst) begin
      q.delete();
      pkt_model   = '0;
      rst_q_model = 1'b1;
    end else begin
      do_push = sv && !rst_q_model && (q.size() < DEPTH);
      do_pop  = (q.size() != 0) && mr;
      if (do_pop) begin
        if (q[0].last) pkt_model = pkt_model + 32'd1;
        void'(q.pop_front());
      end
      if (do_push) begin
        q.push_back('{data: d, keep: k, last: l});
        pushed = 1'b1;
      end
      rst_q_model = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    logic         p;
    logic [W-1:0] d;
    int           beats;
    n_assert    = 0;
    n_fail      = 0;
    checking    = 1'b0;
    pkt_model   = '0;
    rst_q_model = 1'b1;
    rst = 1'b1;
    s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; m_tready = 1'b0;
    @(negedge clk);
    step(1'b0, '0, '0, 1'b0, 1'b0, p);
    step(1'b0, '0, '0, 1'b0, 1'b0, p);
    checking = 1'b1;

    // Reset state, then ready rises one cycle after release.
    rst = 1'b0;
    step(1'b0, '0, '0, 1'b0, 1'b0, p);

    // Single-beat packet through an always-ready sink.
    step(1'b1, W'(1), '1, 1'b1, 1'b1, p);
    step(1'b0, '0, '0, 1'b0, 1'b1, p);
    step(1'b0, '0, '0, 1'b0, 1'b1, p);

    // Fill to full with a stalled sink, then offer one more beat.
    for (int i = 0; i < DEPTH; i++) step(1'b1, W'(i), K'(i), (i % 4) == 3, 1'b0, p);
    step(1'b1, W'(99), '1, 1'b0, 1'b0, p);
    chk("no_push_when_full", W'(p), W'(0));

    // One pop while full with a valid source: no push may slip in.
    step(1'b1, W'(77), '1, 1'b0, 1'b1, p);
    chk("no_push_on_full_pop", W'(p), W'(0));
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, '0, 1'b0, 1'b1, p);

    // Streaming packets of 7 with ~30% sink stalls.
    beats = 0;
    for (int cyc = 0; cyc < 5000 && beats < 1000; cyc++) begin
      d = {$urandom, $urandom};
      step(1'b1, d, K'($urandom), (beats % 7) == 6, $urandom_range(0, 99) >= 30, p);
      if (p) beats++;
    end
    chk("stream_beats", W'(beats), W'(1000));
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, '0, 1'b0, 1'b1, p);

    // Reset with a partial packet stored.
    for (int i = 0; i < 5; i++) step(1'b1, W'(200 + i), '1, 1'b0, 1'b0, p);
    rst = 1'b1;
    step(1'b1, W'(300), '1, 1'b1, 1'b0, p);
    rst = 1'b0;
    step(1'b0, '0, '0, 1'b0, 1'b0, p);
    for (int i = 0; i < 6; i++) step(1'b1, W'(400 + i), K'(i), i == 5, (i % 2) == 1, p);
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b0, 1'b1, p);

    // pkt_count wraps from all-ones to zero.
    step(1'b1, W'(500), '1, 1'b1, 1'b0, p);
    force dut.pkt_count = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_count;
    pkt_model = 32'hFFFF_FFFF;
    step(1'b0, '0, '0, 1'b0, 1'b1, p);
    step(1'b0, '0, '0, 1'b0, 1'b1, p);
    chk("pkt_wrap", W'(pkt), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
